// File: rtl/ssd1306_init_sequencer.sv
// ssd1306_init_sequencer: walks an init ROM and emits command/data bytes
// and timed delays to a display transmitter.
module ssd1306_init_sequencer #(
  parameter int SIZE           = 32,
  parameter int DATA_WIDTH     = 10,
  parameter int TICKS_PER_UNIT = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [$clog2(SIZE)-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0]   rom_data,
  input  logic                    rom_overflow,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_dc,
  output logic                    busy,
  output logic                    done
);
  localparam int AW = $clog2(SIZE);
  localparam int CW = $clog2(255*TICKS_PER_UNIT+1);

  typedef enum logic [2:0] {IDLE, FETCH, SEND, DELAY, DONE} state_t;

  state_t          state, state_n, adv_state;
  logic [AW-1:0]   addr_n, adv_addr;
  logic [CW-1:0]   cnt, cnt_n;
  logic [7:0]      data_n, pl;
  logic            dc_n, last;
  logic [1:0]      op;

  assign op = rom_data[9:8];
  assign pl = rom_data[7:0];
  // The last ROM word finishes the run rather than wrapping back to address 0.
  assign last      = rom_address == AW'(SIZE-1);
  assign adv_state = last ? DONE : FETCH;
  assign adv_addr  = last ? rom_address : rom_address + AW'(1);

  always_comb begin
    state_n = state;
    addr_n  = rom_address;
    cnt_n   = cnt;
    data_n  = tx_data;
    dc_n    = tx_dc;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = FETCH;
        addr_n  = '0;
      end
      FETCH: if (rom_overflow || op == 2'b11) state_n = DONE;
      else if (!op[1]) begin
        data_n  = pl;
        dc_n    = op[0];
        state_n = SEND;
      end else if (pl == 8'd0) begin
        state_n = adv_state;
        addr_n  = adv_addr;
      end else begin
        cnt_n   = CW'(pl) * CW'(TICKS_PER_UNIT);
        state_n = DELAY;
      end
      SEND: if (tx_ready) begin
        state_n = adv_state;
        addr_n  = adv_addr;
      end
      DELAY: begin
        cnt_n = cnt == '0 ? '0 : cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = adv_state;
          addr_n  = adv_addr;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rom_address <= '0;
      cnt         <= '0;
      tx_data     <= 8'h00;
      tx_dc       <= 1'b0;
    end else begin
      state       <= state_n;
      rom_address <= addr_n;
      cnt         <= cnt_n;
      tx_data     <= data_n;
      tx_dc       <= dc_n;
    end
  end

  assign tx_valid = state == SEND;
  assign busy     = state inside {FETCH, SEND, DELAY};
  assign done     = state == DONE;
endmodule
